// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready register slice with a 2-entry skid buffer and synchronous flush.
// Optional statistics counters are enabled by defining PIPE_STAT_CNT_EN.
module pipe_stage_elastic #(
    parameter int unsigned DATA_W   = 69,
    parameter int unsigned CTRL_W   = 6,
    parameter int unsigned CLR_DATA = 1
`ifdef PIPE_STAT_CNT_EN
    ,
    parameter int unsigned CNT_W    = 16
`endif
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              clr_sync,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
`ifdef PIPE_STAT_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              acc;
    logic              take;

    assign acc       = in_valid & in_ready;
    assign take      = out_valid & out_ready;
    assign occupancy = state;

    // MAIN drives the outputs directly; main ctrl is zeroed whenever MAIN goes empty so bubbles are NOPs.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else if (clr_sync) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            skid_ctrl <= '0;
            if (CLR_DATA != 0) begin
                out_data  <= '0;
                skid_data <= '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state     <= ONE;
                        out_valid <= 1'b1;
                        out_data  <= in_data;
                        out_ctrl  <= in_ctrl;
                    end
                end
                ONE: begin
                    if (acc && take) begin
                        out_data <= in_data;
                        out_ctrl <= in_ctrl;
                    end else if (acc) begin
                        state     <= FULL;
                        in_ready  <= 1'b0;
                        skid_data <= in_data;
                        skid_ctrl <= in_ctrl;
                    end else if (take) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        out_ctrl  <= '0;
                    end
                end
                FULL: begin
                    if (take) begin
                        state    <= ONE;
                        in_ready <= 1'b1;
                        out_data <= skid_data;
                        out_ctrl <= skid_ctrl;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_ctrl  <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_STAT_CNT_EN
    // Saturating statistics; only reset clears them.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (clr_sync && (state != EMPTY) && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: directed vector table, random scoreboard run,
// async reset during flush and (with PIPE_STAT_CNT_EN) the statistics counters.
module tb_pipe_stage_elastic;

    localparam int unsigned DW = 69;
    localparam int unsigned CW = 6;
    localparam int unsigned NRAND = 3000;
`ifdef PIPE_STAT_CNT_EN
    localparam int unsigned CNTW = 4;
`endif

    logic          CLK;
    logic          reset;
    logic          clr_sync;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occupancy;
`ifdef PIPE_STAT_CNT_EN
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] flush_cnt;
`endif

    pipe_stage_elastic #(
        .DATA_W  (DW),
        .CTRL_W  (CW),
        .CLR_DATA(1)
`ifdef PIPE_STAT_CNT_EN
        ,
        .CNT_W   (CNTW)
`endif
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .clr_sync (clr_sync),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .occupancy(occupancy)
`ifdef PIPE_STAT_CNT_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       iv;
        logic       ordy;
        logic       clr;
        logic [7:0] d;
        logic [5:0] c;
        logic       ov;
        logic [7:0] od;
        logic [5:0] oc;
        logic [1:0] occ;
        logic       ir;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(logic iv, logic ordy, logic clr, logic [7:0] d, logic [5:0] c,
                                logic ov, logic [7:0] od, logic [5:0] oc, logic [1:0] occ, logic ir);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.clr = clr; v.d = d; v.c = c;
        v.ov = ov; v.od = od; v.oc = oc; v.occ = occ; v.ir = ir;
        return v;
    endfunction

    task automatic check_outputs(input string tag, input logic ov, input logic [DW-1:0] od,
                                 input logic [CW-1:0] oc, input logic [1:0] occ, input logic ir);
        chk({tag, " out_valid"}, 128'(out_valid), 128'(ov));
        chk({tag, " out_data"},  128'(out_data),  128'(od));
        chk({tag, " out_ctrl"},  128'(out_ctrl),  128'(oc));
        chk({tag, " occupancy"}, 128'(occupancy), 128'(occ));
        chk({tag, " in_ready"},  128'(in_ready),  128'(ir));
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic clr,
                         input logic [7:0] d, input logic [5:0] c);
        in_valid  = iv;
        out_ready = ordy;
        clr_sync  = clr;
        in_data   = DW'(d);
        in_ctrl   = CW'(c);
    endtask

    initial begin
        logic [DW+CW-1:0] q[$];
        logic [DW+CW-1:0] exp_e;
        int sent;
        int got;
        int cyc;

        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 6'h00);

        // Inputs are applied #1 after an edge; expected values describe the state after the next edge.
        // Streaming 0x01..0x05 with out_ready held high.
        vecs.push_back(mk(1, 1, 0, 8'h01, 6'h01, 1, 8'h01, 6'h01, 2'd1, 1));
        vecs.push_back(mk(1, 1, 0, 8'h02, 6'h02, 1, 8'h02, 6'h02, 2'd1, 1));
        vecs.push_back(mk(1, 1, 0, 8'h03, 6'h03, 1, 8'h03, 6'h03, 2'd1, 1));
        vecs.push_back(mk(1, 1, 0, 8'h04, 6'h04, 1, 8'h04, 6'h04, 2'd1, 1));
        vecs.push_back(mk(1, 1, 0, 8'h05, 6'h05, 1, 8'h05, 6'h05, 2'd1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h00, 6'h00, 0, 8'h05, 6'h00, 2'd0, 1));
        // Back-pressure fill to two entries, then drain in order.
        vecs.push_back(mk(1, 0, 0, 8'h11, 6'h11, 1, 8'h11, 6'h11, 2'd1, 1));
        vecs.push_back(mk(1, 0, 0, 8'h22, 6'h22, 1, 8'h11, 6'h11, 2'd2, 0));
        vecs.push_back(mk(1, 0, 0, 8'h33, 6'h33, 1, 8'h11, 6'h11, 2'd2, 0));
        vecs.push_back(mk(0, 1, 0, 8'h00, 6'h00, 1, 8'h22, 6'h22, 2'd1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h00, 6'h00, 0, 8'h22, 6'h00, 2'd0, 1));
        // Flush while full with an input offered; held flush drops further inputs.
        vecs.push_back(mk(1, 0, 0, 8'h44, 6'h2D, 1, 8'h44, 6'h2D, 2'd1, 1));
        vecs.push_back(mk(1, 0, 0, 8'h55, 6'h2D, 1, 8'h44, 6'h2D, 2'd2, 0));
        vecs.push_back(mk(1, 1, 1, 8'h66, 6'h2D, 0, 8'h00, 6'h00, 2'd0, 1));
        vecs.push_back(mk(1, 1, 1, 8'h67, 6'h01, 0, 8'h00, 6'h00, 2'd0, 1));
        vecs.push_back(mk(0, 1, 0, 8'h00, 6'h00, 0, 8'h00, 6'h00, 2'd0, 1));
        vecs.push_back(mk(1, 1, 0, 8'h77, 6'h07, 1, 8'h77, 6'h07, 2'd1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h00, 6'h00, 0, 8'h77, 6'h00, 2'd0, 1));

        #12;
        check_outputs("reset_held", 1'b0, '0, '0, 2'd0, 1'b1);
        @(negedge CLK);
        reset = 1'b1;
        @(posedge CLK);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].ordy, vecs[i].clr, vecs[i].d, vecs[i].c);
            @(posedge CLK);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].ov, DW'(vecs[i].od), CW'(vecs[i].oc),
                          vecs[i].occ, vecs[i].ir);
        end

        // Random handshakes against a FIFO scoreboard; transfers are judged at the falling edge.
        sent = 0;
        got  = 0;
        cyc  = 0;
        while ((got < int'(NRAND)) && (cyc < 40000)) begin
            in_valid  = (sent < int'(NRAND)) && ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 1) == 1);
            clr_sync  = 1'b0;
            in_data   = DW'({$urandom, $urandom, $urandom});
            in_ctrl   = CW'($urandom);
            @(negedge CLK);
            chk("rand occupancy", 128'(occupancy), 128'(q.size()));
            chk("rand in_ready", 128'(in_ready), 128'(q.size() < 2));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rand spurious output", 128'(1), 128'(0));
                end else begin
                    exp_e = q.pop_front();
                    chk("rand payload", 128'({out_ctrl, out_data}), 128'(exp_e));
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back({in_ctrl, in_data});
                sent++;
            end
            @(posedge CLK);
            #1;
            cyc++;
        end
        chk("rand drained count", 128'(got), 128'(NRAND));
        chk("rand sent count", 128'(sent), 128'(NRAND));

        // Async reset while full and mid-flush, then one entry through with 1-cycle latency.
        drive(1'b1, 1'b0, 1'b0, 8'hA1, 6'h21);
        @(posedge CLK);
        #1;
        drive(1'b1, 1'b0, 1'b0, 8'hA2, 6'h22);
        @(posedge CLK);
        #1;
        chk("pre_reset occupancy", 128'(occupancy), 128'(2));
        drive(1'b1, 1'b0, 1'b1, 8'hA3, 6'h23);
        #2;
        reset = 1'b0;
        #1;
        check_outputs("async_reset", 1'b0, '0, '0, 2'd0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 6'h00);
        @(negedge CLK);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 8'h77, 6'h05);
        @(posedge CLK);
        #1;
        check_outputs("post_reset", 1'b1, DW'(8'h77), CW'(6'h05), 2'd1, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 6'h00);
        @(posedge CLK);
        #1;
        check_outputs("post_reset_drain", 1'b0, DW'(8'h77), '0, 2'd0, 1'b1);

`ifdef PIPE_STAT_CNT_EN
        // Counters: 20 stall cycles saturate a 4-bit counter; only non-empty flushes count.
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 6'h00);
        @(negedge CLK);
        reset = 1'b1;
        @(posedge CLK);
        #1;
        drive(1'b1, 1'b0, 1'b0, 8'h01, 6'h01);
        @(posedge CLK);
        #1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 6'h00);
        repeat (20) @(posedge CLK);
        #1;
        chk("stall_cnt saturated", 128'(stall_cnt), 128'(4'hF));
        drive(1'b0, 1'b0, 1'b1, 8'h00, 6'h00);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        drive(1'b1, 1'b0, 1'b0, 8'h02, 6'h02);
        @(posedge CLK); #1;
        drive(1'b0, 1'b0, 1'b1, 8'h00, 6'h00);
        @(posedge CLK); #1;
        drive(1'b1, 1'b0, 1'b0, 8'h03, 6'h03);
        @(posedge CLK); #1;
        drive(1'b0, 1'b0, 1'b1, 8'h00, 6'h00);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 6'h00);
        chk("flush_cnt", 128'(flush_cnt), 128'(3));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
